// File: rtl/controller_pio_in_ec.sv
`default_nettype none
// ============================================================================
// Module      : controller_pio_in_ec
// Description : Avalon-MM input PIO slave with multi-stage synchroniser,
//               per-bit glitch filter, edge capture (write-1-to-clear) and
//               a maskable level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module controller_pio_in_ec #(
    parameter int WIDTH         = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int EDGE_MODE     = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]       s;
    logic [SYNC_STAGES-1:0] prime;
    logic                   armed;
    logic [WIDTH-1:0]       filt;
    logic [WIDTH-1:0]       prev;
    logic [WIDTH-1:0]       edge_sel;
    logic [WIDTH-1:0]       edges;
    logic [WIDTH-1:0]       irqmask;
    logic [WIDTH-1:0]       ec;
    logic [WIDTH-1:0]       clr;
    logic                   wr;
    logic [31:0]            rd_mux;
    logic                   unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign s            = sync_q[SYNC_STAGES-1];
    assign unused_wdata = ^writedata;

    // Synchroniser shift chain; the last stage is the usable sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // After reset, wait until the chain holds real samples, then seed filt and
    // prev together so a level already present at release is not seen as an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime <= '0;
            armed <= 1'b0;
        end else begin
            prime <= {prime[SYNC_STAGES-2:0], 1'b1};
            if (prime[SYNC_STAGES-1]) armed <= 1'b1;
        end
    end

    generate
        if (FILTER_CYCLES > 0) begin : g_filter
            localparam int            CW       = $clog2(FILTER_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
            logic [CW-1:0]    cnt [WIDTH];
            logic [WIDTH-1:0] filt_q;

            // Per-bit debounce: a changed bit must hold FILTER_CYCLES cycles
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    filt_q <= '0;
                    for (int b = 0; b < WIDTH; b++) cnt[b] <= '0;
                end else if (!armed) begin
                    if (prime[SYNC_STAGES-1]) filt_q <= s;
                    for (int b = 0; b < WIDTH; b++) cnt[b] <= '0;
                end else begin
                    for (int b = 0; b < WIDTH; b++) begin
                        if (s[b] == filt_q[b]) begin
                            cnt[b] <= '0;
                        end else if (cnt[b] == CNT_LAST) begin
                            filt_q[b] <= s[b];
                            cnt[b]    <= '0;
                        end else begin
                            cnt[b] <= cnt[b] + CW'(1);
                        end
                    end
                end
            end

            assign filt = filt_q;
        end else begin : g_bypass
            assign filt = s;
        end
    endgenerate

    generate
        if (EDGE_MODE == 1) begin : g_fall
            assign edge_sel = ~filt & prev;
        end else if (EDGE_MODE == 2) begin : g_any
            assign edge_sel = filt ^ prev;
        end else begin : g_rise
            assign edge_sel = filt & ~prev;
        end
    endgenerate

    assign edges = armed ? edge_sel : '0;
    assign clr   = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign irq   = |(ec & irqmask);

    // Edge history, edge capture (a new edge beats a same-cycle clear) and mask
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev    <= '0;
            ec      <= '0;
            irqmask <= '0;
        end else begin
            prev <= armed ? filt : s;
            ec   <= (ec & ~clr) | edges;
            if (wr && address == ADDR_MASK) irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Read mux; unused upper bits and the reserved word read as zero
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = filt;
            ADDR_MASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = ec;
            default:   rd_mux            = '0;
        endcase
    end

    // Registered read data, one cycle after the address is presented
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

endmodule
`default_nettype wire

// File: doc/controller_pio_in_ec.md
Name: controller_pio_in_ec

Overview:
Parametrised Avalon-MM input PIO slave for the controller SoC. It generalises the plain read-only input port with:
- a configurable width;
- a multi-stage synchroniser;
- a per-bit glitch filter;
- edge capture with a write-1-to-clear register;
- a maskable interrupt output.

It sits between asynchronous board inputs (BCD switches, buttons, status lines) and the Avalon interconnect.

Parameters:
WIDTH, 16, input port width; legal 1..32.
SYNC_STAGES, 2, synchroniser flops per bit; legal 2..4.
FILTER_CYCLES, 4, consecutive cycles a changed bit must hold before it is accepted; 0 bypasses the filter; legal 0..255.
EDGE_MODE, 0, edge capture type: 0 rising, 1 falling, 2 any.

Ports:
clk  input  1  system clock; all logic on its rising edge
reset_n  input  1  asynchronous active-low reset
address  input  2  Avalon word address
chipselect  input  1  Avalon slave select
write_n  input  1  Avalon write strobe, active low
writedata  input  32  Avalon write data
in_port  input  WIDTH  asynchronous external inputs
readdata  output  32  registered Avalon read data
irq  output  1  level interrupt, active high

Behaviour:
Reset and write strobe:
- One clock; reset is asynchronous and active-low (clk, reset_n).
- Reset clears sync chain, filter counters, filtered data, prev, irqmask, edgecapture and readdata to 0. irq drops to 0 immediately.
- wr = chipselect & ~write_n. Zero wait states; no read strobe is required.

Address map:
- 0: data, RO, filtered value zero-extended.
- 1: reserved, reads 0, writes ignored.
- 2: irqmask, RW, bits [WIDTH-1:0]; upper writedata bits ignored, read as 0.
- 3: edgecapture, read / write-1-to-clear.

Synchroniser:
- Shift chain of SYNC_STAGES flops per bit; s = last stage.

Filter (FILTER_CYCLES > 0), per bit:
- If s == filt: cnt <= 0.
- Else if cnt == FILTER_CYCLES-1: filt <= s, cnt <= 0.
- Else: cnt <= cnt+1.
- cnt width is clog2(FILTER_CYCLES+1).
- A pulse shorter than FILTER_CYCLES cycles after synchronisation never reaches filt.
- FILTER_CYCLES == 0: filt = s combinationally.

Edge detect:
- prev <= filt every cycle.
- rise = filt & ~prev; fall = ~filt & prev; edge is selected by EDGE_MODE.
- Mode 2 uses rise | fall.

Edgecapture update:
- ec <= (ec & ~clr) | edge, where clr = writedata[WIDTH-1:0] when wr & address==3, else 0.
- A simultaneous edge and clear on the same bit leaves the bit set; set wins, so no event is lost.

Irqmask:
- Updated on wr & address==2.

irq:
- irq = |(ec & irqmask), combinational from registers.
- Asserts in the same cycle ec or mask becomes nonzero in an overlapping bit.

readdata:
- readdata <= mux(address) every clock; one-cycle latency.
- A read of address 3 in the cycle of a clear returns the pre-clear value.

Latency:
- Let E0 be the first clock edge sampling a new stable in_port value.
- filt changes at edge E(SYNC_STAGES+FILTER_CYCLES-1).
- data readback (address held 0) and edgecapture/irq update at E(SYNC_STAGES+FILTER_CYCLES).
- FILTER_CYCLES == 0 gives E(SYNC_STAGES).

Reset mid-operation:
- Any in-flight filter count or pending edge is discarded.
- After reset release, an input already high produces no rising edge, because filt and prev rise together.

Test Plan:
All scenarios use defaults (WIDTH=16, SYNC_STAGES=2, FILTER_CYCLES=4, EDGE_MODE=0) unless stated.
1. Reset with in_port=0xFFFF: readdata=0x00000000 and irq=0 during reset. After release, address 0 reads 0x0000FFFF. Edgecapture reads 0, since there was no edge.
2. in_port 0x0000->0x00A5 held, address 0 held: readdata=0x000000A5 first at E6, not at E5. Address 3 reads 0x000000A5 after E6.
3. Glitch bit0 high for 3 cycles, then low: data stays 0x0000, edgecapture stays 0, irq stays 0. A 4-cycle pulse is accepted and sets edgecapture bit0.
4. Write irqmask=0x0001, then rising edge on bit0: irq=1 at E6. Write 0x00000001 to address 3: edgecapture=0 and irq=0 the next cycle. An edge on bit1 alone never raises irq.
5. Write-1-to-clear on bit0 in the same cycle bit0 edge is detected: edgecapture bit0 remains 1 and irq remains 1. EDGE_MODE=2 variant: a falling edge also sets the bit.
6. With irq=1 pending, pulse reset_n low mid-cycle: irq, readdata, irqmask and edgecapture are 0 asynchronously. With in_port held high through release, no edge is captured.
